// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtract engine: one full_subtractor cell walked LSB-first over
// WIDTH-bit operands, with a start/busy/done handshake and registered results.

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, a_sh_next;
  logic [WIDTH-1:0] b_sh_reg, b_sh_next;
  logic [WIDTH-1:0] res_sh_reg, res_sh_next;
  logic             borrow_reg, borrow_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] diff_reg, diff_next;
  logic             bout_reg, bout_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] res_shifted;
  logic             accept;

  full_subtractor u_cell (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .bin  (borrow_reg),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // The newest difference bit enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_shifted = cell_d;
    end else begin : g_res_wn
      assign res_shifted = {cell_d, res_sh_reg[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    a_sh_next   = a_sh_reg;
    b_sh_next   = b_sh_reg;
    res_sh_next = res_sh_reg;
    borrow_next = borrow_reg;
    cnt_next    = cnt_reg;
    diff_next   = diff_reg;
    bout_next   = bout_reg;
    busy_next   = 1'b0;
    done_next   = 1'b0;
    accept      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        accept = start;
      end
      RUN: begin
        a_sh_next   = a_sh_reg >> 1;
        b_sh_next   = b_sh_reg >> 1;
        res_sh_next = res_shifted;
        borrow_next = cell_bout;
        if (cnt_reg == LAST_BIT) begin
          diff_next  = res_shifted;
          bout_next  = cell_bout;
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next  = cnt_reg + 1'b1;
          busy_next = 1'b1;
        end
      end
      DONE: begin
        accept     = start;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (accept) begin
      a_sh_next   = a;
      b_sh_next   = b;
      borrow_next = bin;
      res_sh_next = '0;
      cnt_next    = '0;
      busy_next   = 1'b1;
      done_next   = 1'b0;
      state_next  = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      diff_reg   <= '0;
      bout_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_sh_reg   <= a_sh_next;
      b_sh_reg   <= b_sh_next;
      res_sh_reg <= res_sh_next;
      borrow_reg <= borrow_next;
      cnt_reg    <= cnt_next;
      diff_reg   <= diff_next;
      bout_reg   <= bout_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign diff = diff_reg;
  assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl: vector table, handshake corner cases,
// async reset mid-run and randomised runs at WIDTH 1, 8 and 32.

module tb_serial_subtractor_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         bin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, bout;
  logic [W-1:0] diff;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic rand_go = 1'b0;
  int rand_fin = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [31:0] diff;
    logic        bout;
    int          acc;
  } exp_t;

  exp_t sb[$];

  // Reference model of the handshake for the 8-bit instance
  logic         m_busy = 1'b0, m_done = 1'b0, m_bout = 1'b0;
  logic [W-1:0] m_diff = '0;
  int           m_left = 0;

  always @(posedge clk or posedge rst) begin
    logic [W:0] t;
    exp_t e;
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_diff = '0; m_bout = 1'b0;
      sb.delete();
    end else begin
      cyc++;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          if (sb.size() > 0) begin
            m_diff = sb[0].diff[W-1:0];
            m_bout = sb[0].bout;
          end
        end
      end else begin
        m_done = 1'b0;
        if (start) begin
          t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
          e.diff = 32'(t[W-1:0]);
          e.bout = ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, bin}));
          e.acc  = cyc;
          sb.push_back(e);
          m_busy = 1'b1;
          m_left = W;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("diff_hold", 64'(diff), 64'(m_diff));
    chk("bout_hold", 64'(bout), 64'(m_bout));
    if (done) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_unexpected_done: got done=1, expected no pending op");
      end else begin
        e = sb.pop_front();
        chk("sb_diff", 64'(diff), 64'(e.diff));
        chk("sb_bout", 64'(bout), 64'(e.bout));
        chk("sb_latency", 64'(cyc - e.acc), 64'(W));
      end
    end
  end

  task automatic wait_done();
    int i;
    i = 0;
    while (!done && i < 60) begin
      @(negedge clk);
      i++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done in 60 cycles, expected done");
    end
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                        output logic [W-1:0] od, output logic obo);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; bin = ibin;
    @(negedge clk);
    start = 1'b0; a = W'($urandom()); b = W'($urandom()); bin = 1'($urandom());
    wait_done();
    od = diff;
    obo = bout;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [W-1:0] d;
    logic bo;
    int t0;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
    vecs[4] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_diff", 64'(diff), 64'd0);
    chk("rst_bout", 64'(bout), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, d, bo);
      $display("[TB] vec %0d: %02h - %02h - %0d -> diff=%02h bout=%0d", i, vecs[i].a, vecs[i].b,
               vecs[i].bin, d, bo);
      chk($sformatf("vec%0d_diff", i), 64'(d), 64'(vecs[i].d));
      chk($sformatf("vec%0d_bout", i), 64'(bo), 64'(vecs[i].bo));
    end

    // Result persists after done
    run_op(8'h5A, 8'h3C, 1'b0, d, bo);
    repeat (4) @(negedge clk);
    chk("persist_diff", 64'(diff), 64'h1E);
    chk("persist_bout", 64'(bout), 64'd0);

    // start held high, operands changed mid-run; second op accepted in DONE cycle
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h3C; bin = 1'b0;
    @(negedge clk);
    a = 8'h11; b = 8'h22;
    wait_done();
    chk("held_diff", 64'(diff), 64'h1E);
    chk("held_bout", 64'(bout), 64'd0);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("held2_diff", 64'(diff), 64'hEF);
    chk("held2_bout", 64'(bout), 64'd1);
    $display("[TB] held-start: second op diff=%02h bout=%0d", diff, bout);
    repeat (5) begin
      @(negedge clk);
      chk("no_restart", 64'(busy), 64'd0);
    end

    // Back-to-back start in the DONE cycle
    run_op(8'h5A, 8'h3C, 1'b0, d, bo);
    t0 = cyc;
    start = 1'b1; a = 8'h10; b = 8'h01; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("b2b_edges", 64'(cyc - t0), 64'd9);
    chk("b2b_diff", 64'(diff), 64'h0F);
    chk("b2b_bout", 64'(bout), 64'd0);
    $display("[TB] back-to-back: diff=%02h bout=%0d after %0d edges", diff, bout, cyc - t0);

    // Asynchronous reset just after edge E4 of a run
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h3C; bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_diff", 64'(diff), 64'd0);
    chk("arst_bout", 64'(bout), 64'd0);
    #7 rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("arst_no_done", 64'(done), 64'd0);
    end
    run_op(8'h33, 8'h11, 1'b1, d, bo);
    chk("arst_after_diff", 64'(d), 64'h21);
    chk("arst_after_bout", 64'(bo), 64'd0);
    $display("[TB] after reset: diff=%02h bout=%0d", d, bo);

    rand_go = 1'b1;
    for (int i = 0; i < 80000 && rand_fin < 3; i++) @(negedge clk);
    if (rand_fin < 3) begin
      tests++; fails++;
      $display("FAIL rand_timeout: got %0d campaigns finished, expected 3", rand_fin);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rand
      localparam int RW = (gi == 0) ? 1 : ((gi == 1) ? 8 : 32);
      logic          r_start = 1'b0;
      logic          r_bin = 1'b0;
      logic [RW-1:0] r_a = '0;
      logic [RW-1:0] r_b = '0;
      logic [RW-1:0] r_diff;
      logic          r_busy, r_done, r_bout;
      exp_t          q[$];

      serial_subtractor_ctrl #(.WIDTH(RW)) u_dut (
        .clk(clk), .rst(rst), .start(r_start), .a(r_a), .b(r_b), .bin(r_bin),
        .busy(r_busy), .done(r_done), .diff(r_diff), .bout(r_bout)
      );

      initial begin
        logic [RW-1:0] ta, tb_v;
        logic tbin;
        exp_t e;
        int lat;
        int nfail0;
        wait (rand_go);
        nfail0 = fails;
        for (int n = 0; n < 1000; n++) begin
          ta = RW'($urandom());
          tb_v = RW'($urandom());
          tbin = 1'($urandom());
          if (n == 0) begin ta = '0; tb_v = '1; tbin = 1'b1; end
          if (n == 1) begin ta = '1; tb_v = '0; tbin = 1'b0; end
          e.diff = 32'(RW'(64'(ta) - 64'(tb_v) - 64'(tbin)));
          e.bout = (64'(ta) < (64'(tb_v) + 64'(tbin)));
          e.acc = 0;
          @(negedge clk);
          r_start = 1'b1; r_a = ta; r_b = tb_v; r_bin = tbin;
          q.push_back(e);
          @(negedge clk);
          r_start = 1'b0;
          lat = 0;
          while (!r_done && lat < RW + 5) begin
            @(negedge clk);
            lat++;
          end
          e = q.pop_front();
          if (!r_done) begin
            tests++; fails++;
            $display("FAIL w%0d_timeout: got no done after %0d cycles, expected done", RW, lat);
          end else begin
            chk($sformatf("w%0d_diff", RW), 64'(r_diff), 64'(e.diff));
            chk($sformatf("w%0d_bout", RW), 64'(r_bout), 64'(e.bout));
            chk($sformatf("w%0d_latency", RW), 64'(lat), 64'(RW));
          end
        end
        $display("[TB] random WIDTH=%0d: 1000 ops, %0d new failures", RW, fails - nfail0);
        rand_fin++;
      end
    end
  endgenerate

endmodule
